inst_fetch_q: RTL and testbench
===============================

// Module: inst_fetch_q
// PURPOSE
//  Parametrised instruction fetch unit with a prefetch queue, placed between the PC and decode stages.
//  It holds the PC register and an on-chip instruction RAM with a synchronous read and a boot-load write port.
//  Fetched {pc, instr} pairs go into a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake.
//  Supports branch/jump redirect with queue flush, decode back-pressure in place of a hazard hold, and halt-on-opcode.
// PARAMETERS
//  XLEN      32        PC/instruction width
//  IMEM_WORDS 1024     instruction RAM depth in words (power of 2)
//  QDEPTH    4         prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  32'h0     PC loaded by reset and by start
//  HALT_OPC  6'b111111 instr[31:26] value that halts fetch
// PORTS
//  clk         in  1     clock, rising edge
//  rst         in  1     asynchronous reset, active-high
//  start       in  1     pulse: leave IDLE and begin fetching at RESET_PC
//  load_en     in  1     boot-load write strobe; honoured in IDLE only
//  load_addr   in  $clog2(IMEM_WORDS)  word address for load
//  load_data   in  XLEN  word to write
//  redirect    in  1     branch/jump taken; flushes queue
//  redirect_pc in  XLEN  target PC; bits[1:0] forced to 0
//  inst_valid  out 1     FIFO head valid
//  inst_ready  in  1     decode accepts head this cycle
//  inst_data   out XLEN  head instruction (0 when !inst_valid)
//  inst_pc     out XLEN  head PC (0 when !inst_valid)
//  inst_pc4    out XLEN  inst_pc+4, modulo 2^XLEN (0 when !inst_valid)
//  halted      out 1     state==HALT
//  busy        out 1     state!=IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_pc=RESET_PC, FIFO empty, in-flight read killed. All outputs 0. RAM contents are kept.
//  FSM: IDLE --start--> FETCH. FETCH --HALT_OPC word written into FIFO--> HALT. FETCH/HALT --redirect--> FETCH.
//       A start pulse outside IDLE is ignored.
//  IDLE: load_en writes load_data to ram[load_addr] at the clock edge. No reads are issued. In FETCH/HALT, load_en is ignored.
//  Issue: in FETCH, one read per cycle while (count + inflight) < QDEPTH and !redirect.
//         RAM index = fetch_pc[$clog2(IMEM_WORDS)+1:2]; upper PC bits alias.
//         On issue, fetch_pc <= fetch_pc+4, wrapping 0xFFFFFFFC -> 0.
//  Latency: read data is written into the FIFO at the edge after issue. The earliest inst_valid is 2 cycles after start.
//  Handshake: a pop occurs when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
//             Head outputs are stable while inst_valid && !inst_ready.
//  Full: no issue while count+inflight==QDEPTH, so the FIFO never overflows and no data is dropped.
//        Empty: inst_valid=0, and inst_ready is don't-care.
//  Redirect (FETCH or HALT): at the edge, FIFO cleared, in-flight read discarded (not pushed), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//        Issue is suppressed during the redirect cycle. A pop in the same cycle still completes; decode owns that word.
//  Halt: the HALT_OPC word itself is pushed and delivered. No further issue occurs after it, and its in-flight successor is discarded.
//        Queued words drain normally.
//  Redirect and start/load on the same edge: the FSM rule of the current state decides. In IDLE, redirect is ignored.
// TESTING
//  1 Reset, load ram[0..3]=A,B,C,D, start, ready=1 -> inst_data A,B,C,D on consecutive cycles from start+2.
//    inst_pc 0,4,8,C; inst_pc4 4,8,C,10.
//  2 ready=0 after start -> exactly QDEPTH=4 entries held, no further issue, head=A stable.
//    Then ready=1 -> A,B,C,D,E in order with no loss.
//  3 Redirect to 0x22 while 3 entries are queued -> next inst_valid data=ram[8], inst_pc=0x20, 2 cycles later.
//    Old entries and the in-flight word never appear.
//  4 ram[2]=HALT word -> words 0,1,2 delivered, then halted=1 and inst_valid=0.
//    Redirect to 0x40 -> FETCH resumes at ram[16].
//  5 fetch_pc=0xFFFFFFFC with IMEM_WORDS=1024 -> reads ram[1023], next inst_pc=0, inst_pc4 of 0xFFFFFFFC = 0.
//  6 Assert rst mid-stream, asynchronously off the clock edge -> outputs 0 immediately, state IDLE. RAM unchanged; start refetches A.

Source files
------------

// File: rtl/inst_fetch_q.sv
// rtl/inst_fetch_q.sv - instruction fetch unit: PC, boot-loadable instruction RAM, prefetch FIFO to decode
module inst_fetch_q #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_WORDS = 1024,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [5:0]      HALT_OPC   = 6'b111111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_WORDS)-1:0] load_addr,
  input  logic [XLEN-1:0]               load_data,
  input  logic                          redirect,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [XLEN-1:0]               inst_data,
  output logic [XLEN-1:0]               inst_pc,
  output logic [XLEN-1:0]               inst_pc4,
  output logic                          halted,
  output logic                          busy
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int QW = $clog2(QDEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [QW+1:0]   Q_LIMIT  = (QW+2)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_ALIGN = ~(XLEN'(3));

  logic [1:0]      state;
  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] ram [IMEM_WORDS];
  logic            rd_valid;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] rd_pc;

  logic [XLEN-1:0] q_data [QDEPTH];
  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [QW-1:0]   wr_ptr;
  logic [QW-1:0]   rd_ptr;
  logic [QW:0]     count;

  logic            redir;
  logic            push;
  logic            push_halt;
  logic            pop;
  logic            issue;
  logic [QW+1:0]   occupancy;
  logic [AW-1:0]   ram_idx;

  // Occupancy counts the in-flight read so a full FIFO can always absorb it.
  always_comb begin
    redir     = redirect && (state != S_IDLE);
    push      = rd_valid && (state == S_FETCH) && !redir;
    push_halt = push && (rd_data[XLEN-1 -: 6] == HALT_OPC);
    pop       = inst_valid && inst_ready;
    occupancy = (QW+2)'(count) + (QW+2)'(rd_valid);
    issue     = (state == S_FETCH) && !redir && !push_halt && (occupancy < Q_LIMIT);
    ram_idx   = fetch_pc[AW+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      rd_valid <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          state    <= S_FETCH;
          fetch_pc <= RESET_PC;
        end
      end else if (redirect) begin
        state    <= S_FETCH;
        fetch_pc <= redirect_pc & PC_ALIGN;
      end else begin
        if (push_halt) state <= S_HALT;
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      end
      // A read issued in the halt-push cycle never happens, and redirect kills the in-flight one.
      rd_valid <= issue;
    end
  end

  // RAM contents survive reset, so the array and its read register carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_IDLE) && load_en) ram[load_addr] <= load_data;
    if (issue) begin
      rd_data <= ram[ram_idx];
      rd_pc   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redir) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      count <= count + (QW+1)'(push) - (QW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= rd_data;
      q_pc[wr_ptr]   <= rd_pc;
    end
  end

  always_comb begin
    inst_valid = (count != '0);
    inst_data  = inst_valid ? q_data[rd_ptr] : '0;
    inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;
    inst_pc4   = inst_valid ? (q_pc[rd_ptr] + XLEN'(4)) : '0;
    halted     = (state == S_HALT);
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_inst_fetch_q.sv
// tb/tb_inst_fetch_q.sv - scoreboard bench for inst_fetch_q against a stream-level fetch model
module tb_inst_fetch_q;

  localparam int         XLEN = 32;
  localparam int         NW   = 1024;
  localparam logic [5:0] HALT = 6'b111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        halted;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [31:0] img   [NW];
  logic [31:0] m_ram [NW];
  logic [63:0] exp_q [$];
  bit          m_run;

  inst_fetch_q dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc4(inst_pc4), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Fetch stream from pc: sequential words until (and including) a halt word.
  task automatic gen_stream(input logic [31:0] pc0);
    logic [31:0] pc;
    logic [31:0] w;
    pc = pc0;
    for (int i = 0; i < 1100; i++) begin
      w = m_ram[pc[11:2]];
      exp_q.push_back({pc, w});
      pc = pc + 32'd4;
      if (w[31:26] == HALT) break;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0;
      exp_q.delete();
    end else if (!m_run) begin
      if (load_en) m_ram[load_addr] = load_data;
      if (start) begin
        m_run = 1'b1;
        gen_stream(32'h0);
      end
    end else if (redirect) begin
      exp_q.delete();
      gen_stream({redirect_pc[31:2], 2'b00});
    end
  end

  logic        hold_prev = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", inst_pc, hold_pc);
        check("hold_data", inst_data, hold_data);
      end
      if (inst_valid) begin
        check("pc4", inst_pc4, inst_pc + 32'd4);
        if (inst_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word got pc=%h data=%h expected no word", inst_pc, inst_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", inst_pc, e[63:32]);
            check("sb_data", inst_data, e[31:0]);
          end
        end
      end else begin
        check("empty_zero", inst_data | inst_pc | inst_pc4, 32'd0);
      end
      hold_prev = inst_valid && !inst_ready && !redirect;
      hold_pc   = inst_pc;
      hold_data = inst_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    load_en   = 1'b1;
    load_addr = 10'(addr);
    load_data = w;
    img[addr] = w;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max, output int n);
    n = 0;
    while (!inst_valid && n < max) begin
      tick();
      n++;
    end
    if (!inst_valid) check({name, "_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HALT) w[31] = 1'b0;
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    logic [31:0] hw;
    logic [31:0] rp;

    do_reset();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data | inst_pc | inst_pc4, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NW; i++) load_word(i, rand_word());

    // Straight-line fetch with decode always ready
    inst_ready = 1'b1;
    start_pulse();
    wait_valid("t1_first", 10, n);
    check("t1_latency", 32'(n), 32'd2);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", 32'(inst_valid), 32'd1);
      check("t1_data", inst_data, img[k]);
      check("t1_pc", inst_pc, 32'(4 * k));
      check("t1_pc4", inst_pc4, 32'(4 * k + 4));
      tick();
    end

    // Back-pressure: queue fills, head held, then drains in order
    do_reset();
    inst_ready = 1'b0;
    start_pulse();
    repeat (12) tick();
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_head", inst_data, img[0]);
    check("t2_busy", 32'(busy), 32'd1);
    p0 = pops;
    inst_ready = 1'b1;
    repeat (5) tick();
    check("t2_pops", 32'(pops - p0), 32'd5);

    // Redirect with three queued entries plus one in flight
    do_reset();
    inst_ready = 1'b0;
    start_pulse();
    repeat (4) tick();
    check("t3_pre_pc", inst_pc, 32'h0);
    redirect_to(32'h22);
    check("t3_flush0", 32'(inst_valid), 32'd0);
    tick();
    check("t3_flush1", 32'(inst_valid), 32'd0);
    tick();
    check("t3_valid", 32'(inst_valid), 32'd1);
    check("t3_pc", inst_pc, 32'h20);
    check("t3_data", inst_data, img[8]);
    inst_ready = 1'b1;
    repeat (6) tick();

    // Halt on opcode, then resume by redirect
    do_reset();
    hw = {HALT, 26'h0ABCDE};
    load_word(2, hw);
    inst_ready = 1'b1;
    p0 = pops;
    start_pulse();
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_valid", 32'(inst_valid), 32'd0);
    check("t4_delivered", 32'(pops - p0), 32'd3);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    redirect_to(32'h40);
    check("t4_resume", 32'(halted), 32'd0);
    wait_valid("t4_first", 10, n);
    check("t4_pc", inst_pc, 32'h40);
    check("t4_data", inst_data, img[16]);

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    wait_valid("t5_first", 10, n);
    check("t5_pc", inst_pc, 32'hFFFF_FFFC);
    check("t5_pc4", inst_pc4, 32'h0);
    check("t5_data", inst_data, img[1023]);
    tick();
    check("t5_wrap_pc", inst_pc, 32'h0);
    check("t5_wrap_data", inst_data, img[0]);

    // Asynchronous reset away from the clock edge; redirect in IDLE is ignored
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_zero", inst_data | inst_pc | inst_pc4, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_to(32'h100);
    repeat (3) tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_valid", 32'(inst_valid), 32'd0);
    start_pulse();
    wait_valid("t6_first", 10, n);
    check("t6_pc", inst_pc, 32'h0);
    check("t6_data", inst_data, img[0]);

    // Randomised traffic: ready, redirects, ignored start/load outside IDLE
    do_reset();
    for (int i = 0; i < 4; i++) load_word(int'($urandom_range(20, 1000)), {HALT, 26'($urandom)});
    start_pulse();
    for (int c = 0; c < 2500; c++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      start      = ($urandom_range(0, 29) == 0);
      load_en    = ($urandom_range(0, 29) == 0);
      load_addr  = 10'($urandom);
      load_data  = $urandom;
      redirect   = ($urandom_range(0, 24) == 0) || (halted && $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       rp = $urandom & 32'h0000_0FFF;
        1:       rp = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        default: rp = $urandom;
      endcase
      redirect_pc = rp;
      tick();
    end
    start      = 1'b0;
    load_en    = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
